spi_pwm_multi: RTL and testbench

Multi-channel successor to the single-channel SPI-slave PWM. An SPI slave receives addressed command frames that write or read per-channel duty registers. It drives CHANNELS independent PWM outputs from one shared period counter. Duty updates are double-buffered (shadow to active at period end), so outputs never glitch mid-period. The block sits between an external SPI master and power/LED drivers.

---
 rtl/spi_pwm_pkg.sv | 33 +++
 rtl/spi_pwm_frame_rx.sv | 118 +++++++++++
 rtl/spi_pwm_multi.sv | 133 +++++++++++++
 tb/tb_spi_pwm_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pwm_pkg.sv
// Shared constants, command layout and elaboration-time helpers for the
// multi-channel SPI-controlled PWM block.
package spi_pwm_pkg;

    localparam int CMD_WIDTH   = 8;
    localparam int CMD_W       = 7;
    localparam int CMD_BCAST   = 6;
    localparam int CMD_IDX_MSB = 5;
    localparam int IDX_WIDTH   = CMD_IDX_MSB + 1;

    typedef struct packed {
        logic                 w;
        logic                 bcast;
        logic [IDX_WIDTH-1:0] idx;
    } cmd_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int frame_len(input int duty_width);
        return CMD_WIDTH + duty_width;
    endfunction

endpackage

// File: rtl/spi_pwm_frame_rx.sv
// SPI slave front end: synchronisers, edge detection, bit counting and the
// RX/TX shift registers. Completion signals are single-cycle combinational pulses.
module spi_pwm_frame_rx
    import spi_pwm_pkg::*;
#(
    parameter int DUTY_WIDTH = 8,
    parameter int CPOL       = 1,
    parameter int CPHA       = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  gclk,
    input  logic                  grst_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    input  logic [DUTY_WIDTH-1:0] rd_data,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic [DUTY_WIDTH-1:0] data,
    output logic                  frame_valid,
    output logic                  short_frame,
    output logic                  read_req,
    output logic [IDX_WIDTH-1:0]  read_idx,
    output logic                  miso
);

    localparam int             FL          = frame_len(DUTY_WIDTH);
    localparam int             BCW         = clog2(FL + 1);
    localparam logic [BCW-1:0] FULL        = BCW'(FL);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(FL - 1);
    localparam logic [BCW-1:0] CMD_LAST    = BCW'(CMD_WIDTH - 1);
    localparam bit             SAMPLE_RISE = (CPOL == CPHA);

    // [1] is the synchronised value, [2] the previous one for edge detection
    logic [2:0]            sclk_sy;
    logic [2:0]            cs_sy;
    logic [1:0]            mosi_sy;
    logic                  in_frame;
    logic [BCW-1:0]        bit_cnt;
    logic [FL-1:0]         rx_shift;
    logic [FL-1:0]         rx_next;
    logic [DUTY_WIDTH-1:0] tx_shift;
    logic                  miso_r;
    logic [CMD_WIDTH-1:0]  cmd_early;
    logic                  cmd_unused;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge, take_bit;

    assign sclk_rise   = sclk_sy[1] & ~sclk_sy[2];
    assign sclk_fall   = ~sclk_sy[1] & sclk_sy[2];
    assign cs_rise     = cs_sy[1] & ~cs_sy[2];
    assign cs_fall     = ~cs_sy[1] & cs_sy[2];
    assign sample_edge = in_frame & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = in_frame & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign take_bit    = sample_edge & (bit_cnt < FULL);

    always_comb begin
        if (MSB_FIRST != 0) rx_next = {rx_shift[FL-2:0], mosi_sy[1]};
        else                rx_next = {mosi_sy[1], rx_shift[FL-1:1]};
    end

    // Command byte as it stands once its last bit is taken (before the data field)
    assign cmd_early = (MSB_FIRST != 0) ? rx_next[CMD_WIDTH-1:0] : rx_next[FL-1 -: CMD_WIDTH];
    assign cmd       = (MSB_FIRST != 0) ? rx_next[FL-1 -: CMD_WIDTH] : rx_next[CMD_WIDTH-1:0];
    assign data      = (MSB_FIRST != 0) ? rx_next[DUTY_WIDTH-1:0] : rx_next[FL-1 -: DUTY_WIDTH];

    assign frame_valid = take_bit & (bit_cnt == LAST_BIT);
    assign read_req    = take_bit & (bit_cnt == CMD_LAST) & ~cmd_early[CMD_W];
    assign read_idx    = cmd_early[CMD_IDX_MSB:0];
    assign cmd_unused  = cmd_early[CMD_BCAST];
    assign short_frame = in_frame & cs_rise & (bit_cnt < FULL);
    assign miso        = miso_r & ~cs;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sclk_sy  <= '0;
            cs_sy    <= '0;
            mosi_sy  <= '0;
            in_frame <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso_r   <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[1:0], sclk};
            cs_sy   <= {cs_sy[1:0], cs};
            mosi_sy <= {mosi_sy[0], mosi};
            if (cs_fall) begin
                in_frame <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso_r   <= 1'b0;
            end else if (cs_rise) begin
                in_frame <= 1'b0;
                tx_shift <= '0;
                miso_r   <= 1'b0;
            end else begin
                if (take_bit) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                if (read_req) begin
                    tx_shift <= rd_data;
                end else if (shift_edge) begin
                    if (MSB_FIRST != 0) begin
                        miso_r   <= tx_shift[DUTY_WIDTH-1];
                        tx_shift <= tx_shift << 1;
                    end else begin
                        miso_r   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_pwm_multi.sv
// Multi-channel PWM with SPI-written duty registers; shadow duties move to
// the active set at each period boundary so outputs never change mid-period.
module spi_pwm_multi
    import spi_pwm_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DUTY_WIDTH = 8,
    parameter int MAX_VALUE  = 2**DUTY_WIDTH - 1,
    parameter int PRESCALE   = 16,
    parameter int CPOL       = 1,
    parameter int CPHA       = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                IN_CLOCK,
    input  logic                IN_RESET,
    input  logic                IN_ENABLE,
    input  logic                SCLK,
    input  logic                CS,
    input  logic                MOSI,
    output logic                MISO,
    output logic [CHANNELS-1:0] OUT_PWM_SIGNAL,
    output logic                OUT_FRAME_DONE,
    output logic                OUT_FRAME_ERROR,
    output logic                OUT_PERIOD_START
);

    localparam int                    PW         = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DUTY_WIDTH-1:0] CNT_LAST   = DUTY_WIDTH'(MAX_VALUE - 1);

    logic [CHANNELS-1:0][DUTY_WIDTH-1:0] shadow;
    logic [CHANNELS-1:0][DUTY_WIDTH-1:0] active;
    logic [CHANNELS-1:0]                 pwm_next;
    logic [PW-1:0]                       presc;
    logic [DUTY_WIDTH-1:0]               cnt;
    logic                                en_d;

    logic [CMD_WIDTH-1:0]  cmd_raw;
    cmd_t                  cmd;
    logic [DUTY_WIDTH-1:0] data;
    logic [DUTY_WIDTH-1:0] rd_data;
    logic [IDX_WIDTH-1:0]  read_idx;
    logic frame_valid, short_frame, read_req;
    logic idx_ok, wr_hit, bad_idx, tick, period_end, en_rise;

    spi_pwm_frame_rx #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .MSB_FIRST  (MSB_FIRST)
    ) u_rx (
        .gclk        (IN_CLOCK),
        .grst_n      (IN_RESET),
        .sclk        (SCLK),
        .cs          (CS),
        .mosi        (MOSI),
        .rd_data     (rd_data),
        .cmd         (cmd_raw),
        .data        (data),
        .frame_valid (frame_valid),
        .short_frame (short_frame),
        .read_req    (read_req),
        .read_idx    (read_idx),
        .miso        (MISO)
    );

    assign cmd        = cmd_t'(cmd_raw);
    assign idx_ok     = int'(cmd.idx) < CHANNELS;
    assign wr_hit     = frame_valid & cmd.w & (cmd.bcast | idx_ok);
    assign bad_idx    = frame_valid & ~cmd.bcast & ~idx_ok;
    assign tick       = IN_ENABLE & (presc == PRESC_LAST);
    assign period_end = tick & (cnt == CNT_LAST);
    assign en_rise    = IN_ENABLE & ~en_d;

    // Out-of-range read index falls through to zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (read_req && int'(read_idx) == i) rd_data = active[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign pwm_next[g] = IN_ENABLE & (cnt < active[g]);
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            presc <= '0;
            cnt   <= '0;
            en_d  <= 1'b0;
        end else begin
            en_d <= IN_ENABLE;
            if (!IN_ENABLE) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // A write landing on the copy cycle only reaches active next period
    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (period_end || en_rise) active <= shadow;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit && (cmd.bcast || int'(cmd.idx) == i)) shadow[i] <= data;
            end
        end
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            OUT_PWM_SIGNAL   <= '0;
            OUT_FRAME_DONE   <= 1'b0;
            OUT_FRAME_ERROR  <= 1'b0;
            OUT_PERIOD_START <= 1'b0;
        end else begin
            OUT_PWM_SIGNAL   <= pwm_next;
            OUT_FRAME_DONE   <= frame_valid & ~bad_idx;
            OUT_FRAME_ERROR  <= bad_idx | short_frame;
            OUT_PERIOD_START <= period_end;
        end
    end

endmodule

// File: tb/tb_spi_pwm_multi.sv
// Scoreboarded bench: mode-3 instance for writes/PWM, mode-0 instance for readback.
module tb_spi_pwm_multi;

    localparam int CH  = 4;
    localparam int PER = 255 * 16;
    localparam int H   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en;
    logic sclk0, cs0, mosi0, miso0, done0, err0, ps0;
    logic sclk1, cs1, mosi1, miso1, done1, err1, ps1;
    logic [CH-1:0] pwm0, pwm1;

    spi_pwm_multi #(.CHANNELS(CH)) dut0 (
        .IN_CLOCK(clk), .IN_RESET(rst_n), .IN_ENABLE(en),
        .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0),
        .OUT_PWM_SIGNAL(pwm0), .OUT_FRAME_DONE(done0),
        .OUT_FRAME_ERROR(err0), .OUT_PERIOD_START(ps0)
    );

    spi_pwm_multi #(.CHANNELS(CH), .CPOL(0), .CPHA(0)) dut1 (
        .IN_CLOCK(clk), .IN_RESET(rst_n), .IN_ENABLE(en),
        .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1),
        .OUT_PWM_SIGNAL(pwm1), .OUT_FRAME_DONE(done1),
        .OUT_FRAME_ERROR(err1), .OUT_PERIOD_START(ps1)
    );

    typedef struct {
        logic [1:0] kind;   // 2'b10 done, 2'b01 error
        logic       wr;
        logic       bcast;
        int         idx;
        logic [7:0] data;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] m_shadow[CH];
    logic [7:0] m_active[CH];
    int n_chk = 0, n_fail = 0, n_done1 = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int d, input logic s, input logic c, input logic m);
        if (d == 0) begin sclk0 = s; cs0 = c; mosi0 = m; end
        else        begin sclk1 = s; cs1 = c; mosi1 = m; end
    endtask

    function automatic logic miso_of(input int d);
        return (d == 0) ? miso0 : miso1;
    endfunction

    task automatic push_ev(input logic [1:0] kind, input logic wr, input logic bc,
                           input int idx, input logic [7:0] data);
        ev_t e;
        e.kind = kind; e.wr = wr; e.bcast = bc; e.idx = idx; e.data = data;
        ev_q.push_back(e);
    endtask

    // d=0: mode 3 (CPOL=1,CPHA=1); d=1: mode 0. MSB first; MISO read just before each sample edge.
    task automatic spi_xfer(input int d, input logic [15:0] frm, input int nbits,
                            output logic [15:0] rx, output logic cmd_miso);
        logic cpol, cpha, s, m;
        cpol = (d == 0); cpha = (d == 0);
        rx = '0; cmd_miso = 1'b0; s = cpol; m = 1'b0;
        drive(d, s, 1'b1, 1'b0); cyc(H);
        drive(d, s, 1'b0, 1'b0); cyc(H);
        for (int b = 0; b < nbits; b++) begin
            m = frm[15-b];
            if (cpha) s = ~cpol;
            drive(d, s, 1'b0, m); cyc(H);
            rx = {rx[14:0], miso_of(d)};
            if (b < 8) cmd_miso = cmd_miso | miso_of(d);
            s = ~s; drive(d, s, 1'b0, m); cyc(H);
            if (!cpha) begin s = cpol; drive(d, s, 1'b0, m); end
        end
        cyc(H);
        drive(d, cpol, 1'b1, 1'b0); cyc(2 * H);
    endtask

    task automatic wait_pstart(input int d, input string tag, output logic ok);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!((d == 0) ? ps0 : ps1) && t < PER + 200);
        ok = (d == 0) ? ps0 : ps1;
        if (!ok) chk({tag, "_pstart_timeout"}, 32'(0), 32'(1));
    endtask

    // High-cycle count per channel over one full period of dut0
    task automatic measure(input string tag);
        int hi[CH];
        logic [7:0] ex[CH];
        logic ok;
        wait_pstart(0, tag, ok);
        if (!ok) return;
        foreach (hi[i]) hi[i] = 0;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            if (k == 0) foreach (ex[i]) ex[i] = m_active[i];
            for (int i = 0; i < CH; i++) if (pwm0[i]) hi[i]++;
        end
        for (int i = 0; i < CH; i++)
            chk($sformatf("%s_ch%0d", tag, i), 32'(hi[i]), 32'(ex[i]) * 16);
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n) begin
            if (done1) n_done1++;
            if (ps0) for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
            if (done0 || err0) begin
                if (ev_q.size() == 0) begin
                    chk("evt_unexpected", 32'({done0, err0}), 32'(0));
                end else begin
                    e = ev_q.pop_front();
                    chk("evt_kind", 32'({done0, err0}), 32'(e.kind));
                    if (done0 && e.wr)
                        for (int i = 0; i < CH; i++)
                            if (e.bcast || e.idx == i) m_shadow[i] = e.data;
                end
            end
        end
    end

    initial begin
        logic [15:0] rx;
        logic cm, ok;
        int k;
        rst_n = 1'b0; en = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < CH; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
        cyc(5);
        chk("rst_pwm0", 32'(pwm0), 32'(0));
        chk("rst_flags0", 32'({done0, err0, ps0, miso0}), 32'(0));
        chk("rst_dut1", 32'({pwm1, done1, err1, ps1, miso1}), 32'(0));

        rst_n = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!ps0 && k < PER + 200);
        chk("first_pstart_cycles", 32'(k), 32'(PER));

        // single-channel write
        push_ev(2'b10, 1'b1, 1'b0, 2, 8'h40);
        spi_xfer(0, 16'h8240, 16, rx, cm);
        measure("wr_ch2");

        // broadcast high, then broadcast low written while disabled
        push_ev(2'b10, 1'b1, 1'b1, 0, 8'hFF);
        spi_xfer(0, 16'hC0FF, 16, rx, cm);
        measure("bc_ff");
        en = 1'b0;
        cyc(2);
        chk("dis_pwm", 32'(pwm0), 32'(0));
        push_ev(2'b10, 1'b1, 1'b1, 0, 8'h00);
        spi_xfer(0, 16'hC000, 16, rx, cm);
        en = 1'b1;
        for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
        cyc(20);
        chk("en_reload_pwm", 32'(pwm0), 32'(0));
        measure("bc_00");

        // mode-0 readback of an applied duty
        spi_xfer(1, 16'h8240, 16, rx, cm);
        wait_pstart(1, "d1_apply", ok);
        cyc(4);
        rd_q.push_back(8'h40);
        spi_xfer(1, 16'h0200, 16, rx, cm);
        chk("rd_data", 32'(rx[7:0]), 32'(rd_q.pop_front()));
        chk("rd_cmd_miso", 32'(cm), 32'(0));
        chk("d1_done_cnt", 32'(n_done1), 32'(2));

        // bad index and short frame leave duties alone
        push_ev(2'b10, 1'b1, 1'b0, 1, 8'h80);
        spi_xfer(0, 16'h8180, 16, rx, cm);
        push_ev(2'b01, 1'b0, 1'b0, 0, 8'h00);
        spi_xfer(0, 16'h8510, 16, rx, cm);
        push_ev(2'b01, 1'b0, 1'b0, 0, 8'h00);
        spi_xfer(0, 16'h8355, 10, rx, cm);
        measure("err_keep");

        // reset in the middle of a frame while ch1 is high
        wait_pstart(0, "pre_rst", ok);
        cyc(20);
        drive(0, 1'b1, 1'b0, 1'b0); cyc(H);
        for (int b = 0; b < 6; b++) begin
            drive(0, 1'b0, 1'b0, b[0]); cyc(H);
            drive(0, 1'b1, 1'b0, b[0]); cyc(H);
        end
        chk("pre_rst_ch1", 32'(pwm0[1]), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_pwm", 32'(pwm0), 32'(0));
        chk("rst_mid_flags", 32'({done0, err0, ps0, miso0}), 32'(0));
        ev_q.delete();
        for (int i = 0; i < CH; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
        drive(0, 1'b1, 1'b1, 1'b0);
        cyc(4);
        rst_n = 1'b1;
        push_ev(2'b10, 1'b1, 1'b0, 1, 8'h20);
        spi_xfer(0, 16'h8120, 16, rx, cm);
        measure("post_rst");

        chk("evq_drained", 32'(ev_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
